m_stage: RTL and testbench
==========================

Name: m_stage

Overview:
- Memory stage directly downstream of the execute stage.
- Captures one executed instruction, selects its result (scalar or vector ALU or swap), and performs scalar or vector loads and stores over a byte-wide (ELEM_SIZE) synchronous data-memory port, one element per cycle.
- Presents a single registered writeback record to the writeback stage.
- Stalls upstream during multi-beat memory accesses and halts permanently after an end instruction.

Parameters:
- REGI_BITS, 4, register index width.
- MEMO_LINES, 64, data memory depth in elements; ADDR_W = $clog2(MEMO_LINES).
- REGI_SIZE, 16, scalar width; scalar beats NS = REGI_SIZE/ELEM_SIZE.
- VECT_SIZE, 8, elements per vector; vector beats NV = VECT_SIZE.
- ELEM_SIZE, 8, element and memory word width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  execute-stage instruction valid
- stall_o  out  1  stage busy; upstream holds its inputs
- ialu_res_i  in  REGI_SIZE  scalar ALU result; bits [ADDR_W-1:0] are the memory base address
- valu_res_i  in  ELEM_SIZE*VECT_SIZE  vector ALU result
- iswa_res_i  in  REGI_SIZE  scalar swap result
- vswa_res_i  in  ELEM_SIZE*VECT_SIZE  vector swap result
- int_rsb_i  in  REGI_SIZE  scalar store data
- vec_rsb_i  in  ELEM_SIZE*VECT_SIZE  vector store data
- rd_i  in  REGI_BITS  destination register
- enableMem, flagMemRead, flagMemWrite, enableSwap, flagVec, flagNop, flagEnd  in  1 each  decode controls
- mem_addr_o  out  ADDR_W  memory address (registered)
- mem_wdata_o  out  ELEM_SIZE  memory write data (registered)
- mem_we_o  out  1  memory write enable (registered)
- mem_rdata_i  in  ELEM_SIZE  read data, valid one cycle after the address
- wb_valid_o  out  1  writeback record valid (one-cycle pulse)
- wb_regwrite_o  out  1  record writes a register
- wb_is_vec_o  out  1  record targets the vector register file
- wb_rd_o  out  REGI_BITS  destination
- wb_int_o  out  REGI_SIZE  scalar data
- wb_vec_o  out  ELEM_SIZE*VECT_SIZE  vector data
- wb_end_o  out  1  end-of-program, pulsed with its record

Behaviour:
- **Reset:** every output is 0, state IDLE, beat counter 0. Reset mid-access aborts the access: mem_we_o is 0 in the cycle after reset, and no writeback occurs.
- **States:** IDLE, STORE, LOAD, HALT. stall_o = (state==STORE or LOAD).
- **Accept:** at an edge with valid_i=1 and state IDLE. Inputs are ignored in all other states. Call the accept edge T; "cycle T+k" is the k-th cycle after it.
- **Op decode:**
  - store when enableMem and flagMemWrite;
  - else load when enableMem and flagMemRead (write wins if both are set);
  - else plain.
  - enableMem=0 makes both mem flags ignored.
- **Beats:** N = flagVec ? NV : NS. Beat i addresses (base+i) mod MEMO_LINES; wrap-around is required.
- **Element order:** little-endian. Element i corresponds to bits [8i+7:8i].
- **Plain op:**
  - Writeback record in cycle T+1.
  - Data = enableSwap ? swap result : ALU result, taking the vector or scalar source per flagVec.
  - wb_regwrite_o = !flagNop.
- **Store:**
  - mem_we_o=1 with beat i in cycle T+1+i, for i = 0..N-1.
  - stall_o=1 in cycles T+1..T+N-1.
  - Record with wb_regwrite_o=0 in cycle T+N.
- **Load:**
  - Address beat i in cycle T+1+i; mem_we_o=0.
  - Data for beat i is sampled at the end of cycle T+2+i into the assembly register.
  - stall_o=1 in cycles T+1..T+N+1.
  - Record with wb_regwrite_o=1 in cycle T+N+2, data = assembled value.
- **End:** flagEnd on an accepted instruction completes that instruction normally, with wb_end_o=1 alongside its record, then enters HALT. HALT is left only by reset.
- **wb_* field validity:** fields other than wb_valid_o hold their value between records; they are meaningful only while wb_valid_o=1.
- **Unused outputs:** mem_addr_o and mem_wdata_o hold their value when idle; mem_we_o is 0 outside store beats.
- **At most one record per cycle.** No two operations overlap the memory port.

Test Plan:
- **Plain scalar op:** ialu_res_i=0x1234, enableSwap=0, rd_i=3 -> cycle T+1: wb_valid_o=1, wb_int_o=0x1234, wb_rd_o=3, wb_regwrite_o=1, stall_o never high.
- **Vector store:** base 0x3E, vec_rsb_i=0x0807060504030201 -> mem_we_o pulses at addresses 3E,3F,00,01,…,05 (wrap) with data 01..08; stall_o high for 7 cycles; record with regwrite=0 at T+8.
- **Scalar load** after the memory holds [0x10]=0xCD and [0x11]=0xAB, base 0x10 -> wb_int_o=0xABCD at T+4; a valid_i held during stall is accepted only at the end of T+4.
- **Swap select:** enableSwap=1, flagVec=1, vswa_res_i=0xFF00…00 -> wb_vec_o equals vswa_res_i and wb_is_vec_o=1.
- **End:** flagEnd=1 with a plain op -> wb_end_o=1 with its record; subsequent valid_i pulses produce no records and no memory activity until rst_i.
- **Reset mid-store:** rst_i asserted during beat 3 of a vector store -> next cycle mem_we_o=0, no record, stall_o=0, and a new op is accepted normally afterward.

Source files
------------

// File: rtl/m_stage.sv
// -----------------------------------------------------------------------------
// m_stage -- memory stage directly downstream of the execute stage.
//
// Captures one executed instruction per accept and does one of three things:
//   * plain op : forwards the scalar/vector ALU or swap result as a writeback
//                record one cycle after the accept.
//   * store    : writes the scalar (NS beats) or vector (NV beats) store data
//                one element per cycle, little-endian, addresses wrapping
//                modulo MEMO_LINES, then emits a non-writing record.
//   * load     : reads NS or NV elements through the synchronous memory port
//                (data returns one cycle after its address), assembles them
//                and emits a register-writing record.
// Upstream is stalled while a store or load is in flight. An instruction with
// flagEnd completes normally, pulses wb_end_o with its record, then the stage
// halts until reset.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   valid_i / stall_o    execute-stage handshake (stall = stage busy)
//   ialu_res_i ...       execute results; ialu_res_i[ADDR_W-1:0] is the base
//   int_rsb_i, vec_rsb_i scalar / vector store data
//   rd_i + decode flags  destination register and control bits
//   mem_*                byte-wide synchronous data-memory port (registered)
//   wb_*                 registered writeback record, wb_valid_o is a pulse
// -----------------------------------------------------------------------------
module m_stage #(
  parameter  int REGI_BITS  = 4,
  parameter  int MEMO_LINES = 64,
  parameter  int REGI_SIZE  = 16,
  parameter  int VECT_SIZE  = 8,
  parameter  int ELEM_SIZE  = 8,
  localparam int ADDR_W     = $clog2(MEMO_LINES),
  localparam int VW         = ELEM_SIZE * VECT_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 stall_o,
  input  logic [REGI_SIZE-1:0] ialu_res_i,
  input  logic [VW-1:0]        valu_res_i,
  input  logic [REGI_SIZE-1:0] iswa_res_i,
  input  logic [VW-1:0]        vswa_res_i,
  input  logic [REGI_SIZE-1:0] int_rsb_i,
  input  logic [VW-1:0]        vec_rsb_i,
  input  logic [REGI_BITS-1:0] rd_i,
  input  logic                 enableMem,
  input  logic                 flagMemRead,
  input  logic                 flagMemWrite,
  input  logic                 enableSwap,
  input  logic                 flagVec,
  input  logic                 flagNop,
  input  logic                 flagEnd,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [ELEM_SIZE-1:0] mem_wdata_o,
  output logic                 mem_we_o,
  input  logic [ELEM_SIZE-1:0] mem_rdata_i,
  output logic                 wb_valid_o,
  output logic                 wb_regwrite_o,
  output logic                 wb_is_vec_o,
  output logic [REGI_BITS-1:0] wb_rd_o,
  output logic [REGI_SIZE-1:0] wb_int_o,
  output logic [VW-1:0]        wb_vec_o,
  output logic                 wb_end_o
);

  localparam int NS        = REGI_SIZE / ELEM_SIZE;
  localparam int NV        = VECT_SIZE;
  localparam int MAX_BEATS = (NV > NS) ? NV : NS;
  // The load counter runs one past the last beat (data trails the address).
  localparam int CNT_W     = $clog2(MAX_BEATS + 2);

  typedef enum logic [1:0] {S_IDLE, S_STORE, S_LOAD, S_HALT} state_t;
  typedef enum logic [1:0] {OP_PLAIN, OP_STORE, OP_LOAD} op_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Input-side decode (only meaningful while accepting)
  // ---------------------------------------------------------------------------
  op_t                 op_in;
  logic                accept;
  logic [CNT_W-1:0]    last_in;
  logic [ADDR_W-1:0]   base_in;
  logic [REGI_SIZE-1:0] plain_int;
  logic [VW-1:0]       plain_vec;
  logic [VW-1:0]       store_src;

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op_in = OP_PLAIN;
    // Write wins over read; enableMem=0 masks both flags.
    if (enableMem && flagMemWrite)     op_in = OP_STORE;
    else if (enableMem && flagMemRead) op_in = OP_LOAD;
  end

  assign accept    = valid_i && (state == S_IDLE);
  assign last_in   = flagVec ? CNT_W'(NV - 1) : CNT_W'(NS - 1);
  assign base_in   = ialu_res_i[ADDR_W-1:0];
  assign plain_int = enableSwap ? iswa_res_i : ialu_res_i;
  assign plain_vec = enableSwap ? vswa_res_i : valu_res_i;
  assign store_src = flagVec ? vec_rsb_i
                             : {{(VW - REGI_SIZE){1'b0}}, int_rsb_i};

  // ---------------------------------------------------------------------------
  // Captured operation context
  // ---------------------------------------------------------------------------
  logic                 op_vec;
  logic                 op_end;
  logic [REGI_BITS-1:0] op_rd;
  logic [CNT_W-1:0]     op_last;   // index of the final beat (N-1)
  logic [CNT_W-1:0]     cnt;       // store: next beat; load: cycles in LOAD
  logic [VW-1:0]        sdata;     // remaining store elements, element 0 low
  logic [VW-1:0]        asm_q;     // load assembly register
  logic [VW-1:0]        asm_next;

  logic store_done;
  logic load_done;
  logic load_sample;

  // Store: the beat issued at this edge is the last one.
  assign store_done  = (state == S_STORE) && (cnt == op_last);
  // Load: cnt=c at the end of LOAD cycle c means the data for beat c-1 is on
  // mem_rdata_i; the final beat's data arrives when c = N.
  assign load_sample = (state == S_LOAD) && (cnt != '0);
  assign load_done   = (state == S_LOAD) && (cnt == op_last + CNT_W'(1));

  // Merge the returning element into its little-endian slot.
  always_comb begin
    asm_next = asm_q;
    for (int b = 0; b < VECT_SIZE; b++) begin
      if (load_sample && (cnt == CNT_W'(b + 1))) begin
        asm_next[b*ELEM_SIZE +: ELEM_SIZE] = mem_rdata_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (op_in)
            OP_STORE: begin
              // A single-beat store finishes in the accept cycle itself.
              if (last_in == '0) state_next = flagEnd ? S_HALT : S_IDLE;
              else               state_next = S_STORE;
            end
            OP_LOAD:  state_next = S_LOAD;
            default:  state_next = flagEnd ? S_HALT : S_IDLE;
          endcase
        end
      end
      S_STORE: if (store_done) state_next = op_end ? S_HALT : S_IDLE;
      S_LOAD:  if (load_done)  state_next = op_end ? S_HALT : S_IDLE;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_o = 1'b0;
    if (state == S_STORE || state == S_LOAD) stall_o = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Datapath: memory port, beat sequencing and writeback record
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Aborts any access in flight: no further beats and no record.
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_we_o      <= 1'b0;
      wb_valid_o    <= 1'b0;
      wb_regwrite_o <= 1'b0;
      wb_is_vec_o   <= 1'b0;
      wb_rd_o       <= '0;
      wb_int_o      <= '0;
      wb_vec_o      <= '0;
      wb_end_o      <= 1'b0;
      op_vec        <= 1'b0;
      op_end        <= 1'b0;
      op_rd         <= '0;
      op_last       <= '0;
      cnt           <= '0;
      sdata         <= '0;
      asm_q         <= '0;
    end else begin
      // Pulsed outputs fall back to 0 unless set below.
      mem_we_o   <= 1'b0;
      wb_valid_o <= 1'b0;
      wb_end_o   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_vec  <= flagVec;
            op_end  <= flagEnd;
            op_rd   <= rd_i;
            op_last <= last_in;
            unique case (op_in)
              OP_STORE: begin
                // Beat 0 goes out right away.
                mem_addr_o  <= base_in;
                mem_wdata_o <= store_src[ELEM_SIZE-1:0];
                mem_we_o    <= 1'b1;
                sdata       <= store_src >> ELEM_SIZE;
                cnt         <= CNT_W'(1);
                if (last_in == '0) begin
                  wb_valid_o    <= 1'b1;
                  wb_regwrite_o <= 1'b0;
                  wb_is_vec_o   <= flagVec;
                  wb_rd_o       <= rd_i;
                  wb_end_o      <= flagEnd;
                end
              end
              OP_LOAD: begin
                mem_addr_o <= base_in;
                cnt        <= '0;
                asm_q      <= '0;
              end
              default: begin
                wb_valid_o    <= 1'b1;
                wb_regwrite_o <= !flagNop;
                wb_is_vec_o   <= flagVec;
                wb_rd_o       <= rd_i;
                wb_end_o      <= flagEnd;
                if (flagVec) wb_vec_o <= plain_vec;
                else         wb_int_o <= plain_int;
              end
            endcase
          end
        end

        S_STORE: begin
          // ADDR_W-bit increment gives the modulo-MEMO_LINES wrap.
          mem_addr_o  <= mem_addr_o + ADDR_W'(1);
          mem_wdata_o <= sdata[ELEM_SIZE-1:0];
          mem_we_o    <= 1'b1;
          sdata       <= sdata >> ELEM_SIZE;
          if (store_done) begin
            // Record lands in the same cycle as the final write beat.
            wb_valid_o    <= 1'b1;
            wb_regwrite_o <= 1'b0;
            wb_is_vec_o   <= op_vec;
            wb_rd_o       <= op_rd;
            wb_end_o      <= op_end;
            cnt           <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_LOAD: begin
          asm_q <= asm_next;
          // Addresses run ahead of the returning data by one cycle.
          if (cnt < op_last) mem_addr_o <= mem_addr_o + ADDR_W'(1);
          if (load_done) begin
            wb_valid_o    <= 1'b1;
            wb_regwrite_o <= 1'b1;
            wb_is_vec_o   <= op_vec;
            wb_rd_o       <= op_rd;
            wb_end_o      <= op_end;
            if (op_vec) wb_vec_o <= asm_next;
            else        wb_int_o <= asm_next[REGI_SIZE-1:0];
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: ; // S_HALT: inputs ignored, port quiet, nothing recorded
      endcase
    end
  end

endmodule

// File: tb/tb_m_stage.sv
module tb_m_stage;

  localparam int REGI_BITS  = 4;
  localparam int MEMO_LINES = 64;
  localparam int REGI_SIZE  = 16;
  localparam int VECT_SIZE  = 8;
  localparam int ELEM_SIZE  = 8;
  localparam int ADDR_W     = 6;
  localparam int VW         = 64;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 valid_i;
  logic                 stall_o;
  logic [REGI_SIZE-1:0] ialu_res_i;
  logic [VW-1:0]        valu_res_i;
  logic [REGI_SIZE-1:0] iswa_res_i;
  logic [VW-1:0]        vswa_res_i;
  logic [REGI_SIZE-1:0] int_rsb_i;
  logic [VW-1:0]        vec_rsb_i;
  logic [REGI_BITS-1:0] rd_i;
  logic                 enableMem, flagMemRead, flagMemWrite;
  logic                 enableSwap, flagVec, flagNop, flagEnd;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [ELEM_SIZE-1:0] mem_wdata_o;
  logic                 mem_we_o;
  logic [ELEM_SIZE-1:0] mem_rdata_i;
  logic                 wb_valid_o, wb_regwrite_o, wb_is_vec_o, wb_end_o;
  logic [REGI_BITS-1:0] wb_rd_o;
  logic [REGI_SIZE-1:0] wb_int_o;
  logic [VW-1:0]        wb_vec_o;

  m_stage #(
    .REGI_BITS (REGI_BITS),
    .MEMO_LINES(MEMO_LINES),
    .REGI_SIZE (REGI_SIZE),
    .VECT_SIZE (VECT_SIZE),
    .ELEM_SIZE (ELEM_SIZE)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .stall_o      (stall_o),
    .ialu_res_i   (ialu_res_i),
    .valu_res_i   (valu_res_i),
    .iswa_res_i   (iswa_res_i),
    .vswa_res_i   (vswa_res_i),
    .int_rsb_i    (int_rsb_i),
    .vec_rsb_i    (vec_rsb_i),
    .rd_i         (rd_i),
    .enableMem    (enableMem),
    .flagMemRead  (flagMemRead),
    .flagMemWrite (flagMemWrite),
    .enableSwap   (enableSwap),
    .flagVec      (flagVec),
    .flagNop      (flagNop),
    .flagEnd      (flagEnd),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_we_o     (mem_we_o),
    .mem_rdata_i  (mem_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_regwrite_o(wb_regwrite_o),
    .wb_is_vec_o  (wb_is_vec_o),
    .wb_rd_o      (wb_rd_o),
    .wb_int_o     (wb_int_o),
    .wb_vec_o     (wb_vec_o),
    .wb_end_o     (wb_end_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous data memory: read data one cycle after the address.
  logic [ELEM_SIZE-1:0] mem [MEMO_LINES];
  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= mem[mem_addr_o];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock; afterwards we sit 1 time unit into the following cycle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    valid_i = 0; ialu_res_i = '0; valu_res_i = '0; iswa_res_i = '0;
    vswa_res_i = '0; int_rsb_i = '0; vec_rsb_i = '0; rd_i = '0;
    enableMem = 0; flagMemRead = 0; flagMemWrite = 0; enableSwap = 0;
    flagVec = 0; flagNop = 0; flagEnd = 0;
  endtask

  typedef struct {
    logic [15:0] alu;
    logic [63:0] valu;
    logic [15:0] iswa;
    logic [63:0] vswa;
    logic [3:0]  rd;
    logic        swap;
    logic        vec;
    logic        nop;
    logic [15:0] exp_int;
    logic [63:0] exp_vec;
    logic        exp_rw;
  } plain_vec_t;

  plain_vec_t tbl[5];

  initial begin
    tbl[0] = '{16'h1234, 64'h1111_1111_1111_1111, 16'hDEAD, 64'h2222_2222_2222_2222,
               4'd3, 1'b0, 1'b0, 1'b0, 16'h1234, 64'h0, 1'b1};
    tbl[1] = '{16'h5A5A, 64'h3333_3333_3333_3333, 16'hBEEF, 64'h4444_4444_4444_4444,
               4'd5, 1'b1, 1'b0, 1'b0, 16'hBEEF, 64'h0, 1'b1};
    tbl[2] = '{16'h00FF, 64'h5555_5555_5555_5555, 16'hCAFE, 64'h6666_6666_6666_6666,
               4'd7, 1'b0, 1'b0, 1'b1, 16'h00FF, 64'h0, 1'b0};
    tbl[3] = '{16'h7777, 64'h1122_3344_5566_7788, 16'h8888, 64'h99AA_BBCC_DDEE_FF00,
               4'd2, 1'b0, 1'b1, 1'b0, 16'h0, 64'h1122_3344_5566_7788, 1'b1};
    tbl[4] = '{16'h7777, 64'h0123_4567_89AB_CDEF, 16'h8888, 64'hFF00_0000_0000_0000,
               4'd9, 1'b1, 1'b1, 1'b0, 16'h0, 64'hFF00_0000_0000_0000, 1'b1};

    clear_inputs();
    rst_i = 1;
    tick(); tick();
    // Reset state
    check("rst_stall", stall_o, 0);
    check("rst_we", mem_we_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_int", wb_int_o, 0);
    check("rst_wb_vec", wb_vec_o, 0);
    check("rst_wb_end", wb_end_o, 0);
    rst_i = 0;
    tick();

    // ---------------- Plain ops, table driven ----------------
    for (int i = 0; i < 5; i++) begin
      ialu_res_i = tbl[i].alu;  valu_res_i = tbl[i].valu;
      iswa_res_i = tbl[i].iswa; vswa_res_i = tbl[i].vswa;
      rd_i = tbl[i].rd; enableSwap = tbl[i].swap;
      flagVec = tbl[i].vec; flagNop = tbl[i].nop;
      valid_i = 1;
      tick();  // cycle T+1
      valid_i = 0;
      check($sformatf("plain%0d_valid", i), wb_valid_o, 1);
      check($sformatf("plain%0d_rd", i), wb_rd_o, tbl[i].rd);
      check($sformatf("plain%0d_rw", i), wb_regwrite_o, tbl[i].exp_rw);
      check($sformatf("plain%0d_isvec", i), wb_is_vec_o, tbl[i].vec);
      check($sformatf("plain%0d_stall", i), stall_o, 0);
      check($sformatf("plain%0d_end", i), wb_end_o, 0);
      check($sformatf("plain%0d_we", i), mem_we_o, 0);
      if (tbl[i].vec) check($sformatf("plain%0d_vec", i), wb_vec_o, tbl[i].exp_vec);
      else            check($sformatf("plain%0d_int", i), wb_int_o, tbl[i].exp_int);
      tick();
      check($sformatf("plain%0d_pulse", i), wb_valid_o, 0);
      clear_inputs();
    end

    // ---------------- Scalar store 0xABCD at 0x10 ----------------
    ialu_res_i = 16'h0010; int_rsb_i = 16'hABCD; rd_i = 4'd6;
    enableMem = 1; flagMemWrite = 1; valid_i = 1;
    tick();  // T+1
    clear_inputs();
    check("sst_b0_we", mem_we_o, 1);
    check("sst_b0_addr", mem_addr_o, 6'h10);
    check("sst_b0_data", mem_wdata_o, 8'hCD);
    check("sst_b0_stall", stall_o, 1);
    check("sst_b0_novalid", wb_valid_o, 0);
    tick();  // T+2
    check("sst_b1_we", mem_we_o, 1);
    check("sst_b1_addr", mem_addr_o, 6'h11);
    check("sst_b1_data", mem_wdata_o, 8'hAB);
    check("sst_b1_stall", stall_o, 0);
    check("sst_rec_valid", wb_valid_o, 1);
    check("sst_rec_rw", wb_regwrite_o, 0);
    tick();  // T+3
    check("sst_done_we", mem_we_o, 0);
    check("sst_done_valid", wb_valid_o, 0);

    // ---------------- Vector store at 0x3E (wrap) ----------------
    ialu_res_i = 16'h003E; vec_rsb_i = 64'h0807_0605_0403_0201;
    enableMem = 1; flagMemWrite = 1; flagMemRead = 1; flagVec = 1; valid_i = 1;
    tick();
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      logic [5:0] ea;
      ea = 6'(62 + i);
      check($sformatf("vst_b%0d_we", i), mem_we_o, 1);
      check($sformatf("vst_b%0d_addr", i), mem_addr_o, ea);
      check($sformatf("vst_b%0d_data", i), mem_wdata_o, 8'(i + 1));
      check($sformatf("vst_b%0d_stall", i), stall_o, (i < 7) ? 1 : 0);
      check($sformatf("vst_b%0d_valid", i), wb_valid_o, (i == 7) ? 1 : 0);
      tick();
    end
    // now in T+9; the record was checked at T+8 above
    check("vst_after_we", mem_we_o, 0);
    check("vst_after_valid", wb_valid_o, 0);

    // ---------------- Scalar load from 0x10, valid held during stall ------
    ialu_res_i = 16'h0010; rd_i = 4'd4; enableMem = 1; flagMemRead = 1; valid_i = 1;
    tick();  // T+1
    // Next instruction waits with valid held high.
    clear_inputs();
    ialu_res_i = 16'h5555; rd_i = 4'd8; valid_i = 1;
    check("sld_t1_stall", stall_o, 1);
    check("sld_t1_addr", mem_addr_o, 6'h10);
    check("sld_t1_we", mem_we_o, 0);
    check("sld_t1_valid", wb_valid_o, 0);
    tick();  // T+2
    check("sld_t2_stall", stall_o, 1);
    check("sld_t2_addr", mem_addr_o, 6'h11);
    check("sld_t2_valid", wb_valid_o, 0);
    tick();  // T+3
    check("sld_t3_stall", stall_o, 1);
    check("sld_t3_valid", wb_valid_o, 0);
    tick();  // T+4
    check("sld_t4_stall", stall_o, 0);
    check("sld_t4_valid", wb_valid_o, 1);
    check("sld_t4_int", wb_int_o, 16'hABCD);
    check("sld_t4_rw", wb_regwrite_o, 1);
    check("sld_t4_rd", wb_rd_o, 4);
    check("sld_t4_isvec", wb_is_vec_o, 0);
    tick();  // T+5: the held instruction was accepted at the end of T+4
    valid_i = 0;
    check("sld_next_valid", wb_valid_o, 1);
    check("sld_next_int", wb_int_o, 16'h5555);
    check("sld_next_rd", wb_rd_o, 8);
    clear_inputs();
    tick();

    // ---------------- Vector load from 0x3E (wrap) ----------------
    ialu_res_i = 16'h003E; rd_i = 4'd1; enableMem = 1; flagMemRead = 1; flagVec = 1;
    valid_i = 1;
    tick();
    clear_inputs();
    for (int k = 1; k < 10; k++) begin
      check($sformatf("vld_t%0d_stall", k), stall_o, 1);
      check($sformatf("vld_t%0d_valid", k), wb_valid_o, 0);
      tick();
    end
    check("vld_rec_valid", wb_valid_o, 1);
    check("vld_rec_vec", wb_vec_o, 64'h0807_0605_0403_0201);
    check("vld_rec_isvec", wb_is_vec_o, 1);
    check("vld_rec_stall", stall_o, 0);
    tick();

    // ---------------- End, then halt ----------------
    ialu_res_i = 16'h0042; rd_i = 4'd1; flagEnd = 1; valid_i = 1;
    tick();
    clear_inputs();
    check("end_valid", wb_valid_o, 1);
    check("end_flag", wb_end_o, 1);
    check("end_int", wb_int_o, 16'h0042);
    ialu_res_i = 16'h0005; int_rsb_i = 16'h7E7E;
    enableMem = 1; flagMemWrite = 1; valid_i = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("halt%0d_valid", k), wb_valid_o, 0);
      check($sformatf("halt%0d_we", k), mem_we_o, 0);
      check($sformatf("halt%0d_stall", k), stall_o, 0);
      check($sformatf("halt%0d_end", k), wb_end_o, 0);
    end
    clear_inputs();
    rst_i = 1;
    tick();
    rst_i = 0;

    // ---------------- Reset mid vector store ----------------
    ialu_res_i = 16'h0020; vec_rsb_i = 64'hA8A7_A6A5_A4A3_A2A1;
    enableMem = 1; flagMemWrite = 1; flagVec = 1; valid_i = 1;
    tick();  // T+1
    clear_inputs();
    tick(); tick(); tick();  // T+4: beat 3
    check("rms_b3_we", mem_we_o, 1);
    check("rms_b3_addr", mem_addr_o, 6'h23);
    check("rms_b3_data", mem_wdata_o, 8'hA4);
    rst_i = 1;
    tick();
    rst_i = 0;
    check("rms_we", mem_we_o, 0);
    check("rms_valid", wb_valid_o, 0);
    check("rms_stall", stall_o, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rms_quiet%0d_valid", k), wb_valid_o, 0);
      check($sformatf("rms_quiet%0d_we", k), mem_we_o, 0);
    end
    ialu_res_i = 16'h0BAD; rd_i = 4'd15; valid_i = 1;
    tick();
    clear_inputs();
    check("rms_new_valid", wb_valid_o, 1);
    check("rms_new_int", wb_int_o, 16'h0BAD);
    check("rms_new_rd", wb_rd_o, 15);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
